// File: rtl/exec_controller.sv
// Run/halt/single-step sequencer generating the core's global execute enable.
// Define BREAKPOINT_EN to build the PC breakpoint comparator and its halt cause.
module exec_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] EBREAK_INSTR    = 32'h00100073
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_sw_i,
    input  logic        step_btn_i,
    input  logic        halt_req_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] bp_addr_i,
    input  logic        bp_valid_i,
    output logic        cpu_en_o,
    output logic [1:0]  state_o,
    output logic [1:0]  halt_cause_o,
    output logic [31:0] retired_o
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_e;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_HALT  = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_EBRK  = 2'b11;

    localparam int unsigned           CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic              skip_q, skip_d;
    logic [31:0]       retired_q, retired_d;
    logic              sync1_q, sync2_q, deb_q, deb_prev_q;
    logic [CNT_W-1:0]  deb_cnt_q;
    logic              step_pulse, bp_hit, eb_hit, cpu_en;

    // Debounced level changes only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            sync1_q    <= step_btn_i;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == CNT_LAST) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    assign step_pulse = deb_q & ~deb_prev_q;

`ifdef BREAKPOINT_EN
    assign bp_hit = bp_valid_i & (pc_i == bp_addr_i) & ~skip_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr_i, bp_valid_i};
    assign bp_hit    = 1'b0;
`endif

    // skip also masks EBREAK so resuming at a trapped EBREAK executes it once.
    assign eb_hit = (instr_i == EBREAK_INSTR) & ~skip_q;

    assign cpu_en = ~reset & (((state_q == ST_RUN) & ~halt_req_i & ~bp_hit & ~eb_hit)
                              | (state_q == ST_STEP));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        skip_d    = 1'b0;
        retired_d = retired_q + {31'b0, cpu_en};
        unique case (state_q)
            ST_HALT: begin
                if (halt_req_i) begin
                    state_d = ST_HALT;
                end else if (run_sw_i) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                    cause_d = CAUSE_NONE;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_req_i) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_HALT;
                end else if (eb_hit) begin
                    state_d = ST_BREAK;
                    cause_d = CAUSE_EBRK;
                end else if (bp_hit) begin
                    state_d = ST_BREAK;
                    cause_d = CAUSE_BP;
                end else if (!run_sw_i) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_HALT;
                end
            end
            ST_STEP: state_d = ST_HALT;
            ST_BREAK: begin
                if (halt_req_i || !run_sw_i) begin
                    state_d = ST_HALT;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HALT;
            cause_q   <= CAUSE_NONE;
            skip_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            skip_q    <= skip_d;
            retired_q <= retired_d;
        end
    end

    assign cpu_en_o     = cpu_en;
    assign state_o      = state_q;
    assign halt_cause_o = cause_q;
    assign retired_o    = retired_q;

endmodule
